// File: rtl/dmem_cache.sv
// -----------------------------------------------------------------------------
// dmem_cache -- direct-mapped, write-back data cache with 16-byte blocks.
//
// Sits between a CPU load/store port and a block-wide main memory. Hits are
// answered combinationally in the same cycle. A miss stalls the CPU while the
// controller writes back a dirty victim (WRITEBACK), fetches the new block
// (FETCH) and installs it (UPDATE). After that the held request hits.
//
// Ports
//   clk_i, rst_ni      rising-edge clock, asynchronous active-low reset
//   read_i[3:0]        bit3 load enable, bits[2:0] funct3 (LB/LH/LW/LBU/LHU)
//   write_i[2:0]       bit2 store enable, bits[1:0] size (SB/SH/SW)
//   address_i          CPU byte address
//   writedata_i        store data, right-aligned
//   readdata_o         load result, sign/zero extended; 0 when not a read hit
//   busywait_o         CPU must stall and hold its request
//   mem_read_o/_write_o      block read / write strobes to main memory
//   mem_address_o      block address (byte address[31:4])
//   mem_writedata_o    victim block
//   mem_readdata_i     fetched block
//   mem_busywait_i     main memory still servicing the strobe
//
// Optional feature: define DCACHE_STATS_EN to add the hit_count_o and
// miss_count_o statistics outputs.
// -----------------------------------------------------------------------------
module dmem_cache #(
    parameter int LINES = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [3:0]   read_i,
    input  logic [2:0]   write_i,
    input  logic [31:0]  address_i,
    input  logic [31:0]  writedata_i,
    output logic [31:0]  readdata_o,
    output logic         busywait_o,
    output logic         mem_read_o,
    output logic         mem_write_o,
    output logic [27:0]  mem_address_o,
    output logic [127:0] mem_writedata_o,
    input  logic [127:0] mem_readdata_i,
    input  logic         mem_busywait_i
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]  hit_count_o,
    output logic [31:0]  miss_count_o
`endif
);

    localparam int IDXW = $clog2(LINES);
    localparam int TAGW = 28 - IDXW;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_WRITEBACK = 2'd1;
    localparam logic [1:0] ST_FETCH     = 2'd2;
    localparam logic [1:0] ST_UPDATE    = 2'd3;

    logic [1:0]      state_q, state_d, prev_state_q;
    logic [LINES-1:0] valid_q, dirty_q;
    logic [TAGW-1:0] tag_q [LINES];
    logic [127:0]    data_q [LINES];
    logic [127:0]    fill_q, fill_d;

    logic            mem_read_d, mem_write_d;
    logic [27:0]     mem_address_d;
    logic [127:0]    mem_writedata_d;

    logic            rd_en_s, wr_en_s, req_s, hit_s, miss_s, wr_hit_s;
    logic [IDXW-1:0] idx_s;
    logic [TAGW-1:0] tag_s;
    logic [3:0]      off_s;
    logic [127:0]    line_s, wline_s;
    logic [7:0]      byte_s;
    logic [15:0]     half_s;
    logic [31:0]     word_s, rdata_s;

    assign rd_en_s  = read_i[3];
    assign wr_en_s  = write_i[2];
    assign req_s    = rd_en_s | wr_en_s;
    assign idx_s    = address_i[4 +: IDXW];
    assign tag_s    = address_i[31 -: TAGW];
    assign off_s    = address_i[3:0];
    assign line_s   = data_q[idx_s];
    assign hit_s    = req_s && valid_q[idx_s] && (tag_q[idx_s] == tag_s);
    assign miss_s   = (state_q == ST_IDLE) && req_s && !hit_s;
    // A store wins over a simultaneous load.
    assign wr_hit_s = (state_q == ST_IDLE) && wr_en_s && hit_s;

    assign busywait_o = (req_s && !hit_s) || (state_q != ST_IDLE);

    // Sub-word lanes; halfword and word offsets are aligned down.
    assign byte_s = line_s[{off_s, 3'b000} +: 8];
    assign half_s = line_s[{off_s[3:1], 4'b0000} +: 16];
    assign word_s = line_s[{off_s[3:2], 5'b00000} +: 32];

    // Load result with extension; zero unless this is a pure load hit.
    always_comb begin
        rdata_s = 32'h0000_0000;
        if (rd_en_s && !wr_en_s && hit_s && (state_q == ST_IDLE)) begin
            case (read_i[2:0])
                3'b000:  rdata_s = {{24{byte_s[7]}}, byte_s};
                3'b001:  rdata_s = {{16{half_s[15]}}, half_s};
                3'b010:  rdata_s = word_s;
                3'b100:  rdata_s = {24'h00_0000, byte_s};
                3'b101:  rdata_s = {16'h0000, half_s};
                default: rdata_s = 32'h0000_0000;
            endcase
        end else begin
            rdata_s = 32'h0000_0000;
        end
    end

    assign readdata_o = rdata_s;

    // Merge store data into the addressed line.
    always_comb begin
        wline_s = line_s;
        case (write_i[1:0])
            2'b00:   wline_s[{off_s, 3'b000} +: 8]         = writedata_i[7:0];
            2'b01:   wline_s[{off_s[3:1], 4'b0000} +: 16]  = writedata_i[15:0];
            2'b10:   wline_s[{off_s[3:2], 5'b00000} +: 32] = writedata_i;
            default: wline_s = line_s;
        endcase
    end

    // Miss-handling FSM next state and fill-buffer capture.
    always_comb begin
        state_d = state_q;
        fill_d  = fill_q;
        case (state_q)
            ST_IDLE: begin
                if (miss_s) begin
                    state_d = (valid_q[idx_s] && dirty_q[idx_s]) ? ST_WRITEBACK : ST_FETCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRITEBACK: begin
                // The first strobe cycle is ignored: memory may not have
                // raised its busy flag yet.
                if ((prev_state_q == ST_WRITEBACK) && !mem_busywait_i) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_WRITEBACK;
                end
            end
            ST_FETCH: begin
                if (!mem_busywait_i) begin
                    state_d = ST_UPDATE;
                    fill_d  = mem_readdata_i;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_UPDATE: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Memory strobes follow the state being entered so they are registered.
    always_comb begin
        mem_read_d      = (state_d == ST_FETCH);
        mem_write_d     = (state_d == ST_WRITEBACK);
        mem_address_d   = 28'h000_0000;
        mem_writedata_d = 128'h0;
        if (state_d == ST_WRITEBACK) begin
            mem_address_d   = {tag_q[idx_s], idx_s};
            mem_writedata_d = line_s;
        end else if (state_d == ST_FETCH) begin
            mem_address_d   = address_i[31:4];
        end else begin
            mem_address_d   = 28'h000_0000;
        end
    end

    // Control state, line status bits and memory-side outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q         <= ST_IDLE;
            prev_state_q    <= ST_IDLE;
            valid_q         <= '0;
            dirty_q         <= '0;
            fill_q          <= 128'h0;
            mem_read_o      <= 1'b0;
            mem_write_o     <= 1'b0;
            mem_address_o   <= 28'h000_0000;
            mem_writedata_o <= 128'h0;
        end else begin
            state_q         <= state_d;
            prev_state_q    <= state_q;
            fill_q          <= fill_d;
            mem_read_o      <= mem_read_d;
            mem_write_o     <= mem_write_d;
            mem_address_o   <= mem_address_d;
            mem_writedata_o <= mem_writedata_d;
            if (state_q == ST_UPDATE) begin
                valid_q[idx_s] <= 1'b1;
                dirty_q[idx_s] <= 1'b0;
            end else if (wr_hit_s) begin
                dirty_q[idx_s] <= 1'b1;
            end
        end
    end

    // Tag and data arrays; contents are meaningless until the valid bit is set.
    always_ff @(posedge clk_i) begin
        if (state_q == ST_UPDATE) begin
            data_q[idx_s] <= fill_q;
            tag_q[idx_s]  <= tag_s;
        end else if (wr_hit_s) begin
            data_q[idx_s] <= wline_s;
        end
    end

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_count_q, miss_count_q;

    // Statistics: the hit that completes a refill is counted as the miss only.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hit_count_q  <= 32'd0;
            miss_count_q <= 32'd0;
        end else begin
            if ((state_q == ST_IDLE) && hit_s && (prev_state_q != ST_UPDATE)) begin
                hit_count_q <= hit_count_q + 32'd1;
            end
            if (miss_s) begin
                miss_count_q <= miss_count_q + 32'd1;
            end
        end
    end

    assign hit_count_o  = hit_count_q;
    assign miss_count_o = miss_count_q;
`endif

endmodule

// File: tb/tb_dmem_cache.sv
module tb_dmem_cache;
    localparam int N_BUSY = 3;

    localparam logic [3:0] LB  = 4'b1000, LH  = 4'b1001, LW = 4'b1010;
    localparam logic [3:0] LBU = 4'b1100, LHU = 4'b1101, NR = 4'b0000;
    localparam logic [2:0] SB  = 3'b100,  SH  = 3'b101,  SW = 3'b110, NW = 3'b000;

    logic         clk_i = 1'b0;
    logic         rst_ni = 1'b0;
    logic [3:0]   read_i = 4'h0;
    logic [2:0]   write_i = 3'h0;
    logic [31:0]  address_i = 32'h0;
    logic [31:0]  writedata_i = 32'h0;
    logic [31:0]  readdata_o;
    logic         busywait_o;
    logic         mem_read_o, mem_write_o;
    logic [27:0]  mem_address_o;
    logic [127:0] mem_writedata_o;
    logic [127:0] mem_readdata_i = 128'h0;
    logic         mem_busywait_i = 1'b0;
`ifdef DCACHE_STATS_EN
    logic [31:0]  hit_count_o, miss_count_o;
`endif

    dmem_cache #(.LINES(8)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .read_i         (read_i),
        .write_i        (write_i),
        .address_i      (address_i),
        .writedata_i    (writedata_i),
        .readdata_o     (readdata_o),
        .busywait_o     (busywait_o),
        .mem_read_o     (mem_read_o),
        .mem_write_o    (mem_write_o),
        .mem_address_o  (mem_address_o),
        .mem_writedata_o(mem_writedata_o),
        .mem_readdata_i (mem_readdata_i),
        .mem_busywait_i (mem_busywait_i)
`ifdef DCACHE_STATS_EN
        ,
        .hit_count_o    (hit_count_o),
        .miss_count_o   (miss_count_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] rdata;
        int          stalls;   // -1: latency not checked
    } rsp_t;

    typedef struct {
        logic         is_wr;
        logic [27:0]  addr;
        logic [127:0] data;
    } mev_t;

    rsp_t rsp_q[$];
    mev_t mev_q[$];
    logic [127:0] mem_model [logic [27:0]];

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;
    int stall_cnt = 0;
    int mcyc = 0;
    int exp_hits = 0;
    int exp_miss = 0;
    logic last_rd = 1'b0;
    logic last_wr = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: completes CPU accesses, checks memory strobes, models main memory.
    always @(negedge clk_i) begin : monitor
        rsp_t r;
        mev_t m;
        logic req;
        if (!rst_ni) begin
            stall_cnt      = 0;
            mcyc           = 0;
            last_rd        = 1'b0;
            last_wr        = 1'b0;
            mem_busywait_i = 1'b0;
            exp_hits       = 0;
            exp_miss       = 0;
        end else begin
            req = read_i[3] | write_i[2];
            check("strobe_exclusive", {127'h0, mem_read_o & mem_write_o}, 128'h0);
            if (req) begin
                if (busywait_o) begin
                    stall_cnt++;
                    check("rdata_while_stalled", {96'h0, readdata_o}, 128'h0);
                end else begin
                    if (rsp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_completion: got addr %h expected none", address_i);
                    end else begin
                        r = rsp_q.pop_front();
                        check("readdata", {96'h0, readdata_o}, {96'h0, r.rdata});
                        if (r.stalls >= 0) begin
                            check("stall_cycles", stall_cnt, r.stalls);
                        end
                    end
                    if (stall_cnt == 0) exp_hits++;
                    else exp_miss++;
                    stall_cnt = 0;
                    done_cnt++;
                end
            end else begin
                stall_cnt = 0;
            end
            if ((mem_read_o && !last_rd) || (mem_write_o && !last_wr)) begin
                if (mev_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_strobe: got wr=%0b addr %h expected none", mem_write_o, mem_address_o);
                end else begin
                    m = mev_q.pop_front();
                    check("strobe_kind", {127'h0, mem_write_o}, {127'h0, m.is_wr});
                    check("mem_address", {100'h0, mem_address_o}, {100'h0, m.addr});
                    if (m.is_wr) check("mem_writedata", mem_writedata_o, m.data);
                end
            end
            // Each strobe occupies N_BUSY cycles: busy for all but the last one.
            if (mem_read_o || mem_write_o) begin
                if ((mem_read_o && last_rd) || (mem_write_o && last_wr)) mcyc++;
                else mcyc = 1;
            end else begin
                mcyc = 0;
            end
            mem_busywait_i = (mcyc >= 1) && (mcyc < N_BUSY);
            if (mem_write_o && mcyc == 1) mem_model[mem_address_o] = mem_writedata_o;
            if (mem_read_o) begin
                mem_readdata_i = mem_model.exists(mem_address_o) ? mem_model[mem_address_o] : 128'h0;
            end
            last_rd = mem_read_o;
            last_wr = mem_write_o;
        end
    end

    task automatic expect_mem(input logic is_wr, input logic [27:0] addr, input logic [127:0] data);
        mev_t m;
        m.is_wr = is_wr;
        m.addr  = addr;
        m.data  = data;
        mev_q.push_back(m);
    endtask

    task automatic access(input logic [3:0] rd, input logic [2:0] wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp, input int stalls);
        rsp_t r;
        int start;
        r.rdata  = exp;
        r.stalls = stalls;
        rsp_q.push_back(r);
        start = done_cnt;
        read_i      = rd;
        write_i     = wr;
        address_i   = addr;
        writedata_i = wdata;
        for (int i = 0; i < 100 && done_cnt == start; i++) begin
            @(posedge clk_i);
            #1;
        end
        if (done_cnt == start) begin
            tests++;
            fails++;
            $display("FAIL access_timeout: got no completion for addr %h expected one", addr);
            void'(rsp_q.pop_back());
        end
        read_i  = NR;
        write_i = NW;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        mem_model[28'h0000004] = {32'hEEEEFFFF, 32'hDDDDCCCC, 32'hBBBBAAAA, 32'h11223344};
        mem_model[28'h000000C] = {32'h0C0C0C0C, 32'h0B0B0B0B, 32'h0A0A0A0A, 32'hA5A50001};
        mem_model[28'h0000010] = {32'h44444444, 32'h33333333, 32'h22222222, 32'h9ABCDEF0};

        // Reset state
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_busywait", {127'h0, busywait_o}, 128'h0);
        check("rst_readdata", {96'h0, readdata_o}, 128'h0);
        check("rst_mem_read", {127'h0, mem_read_o}, 128'h0);
        check("rst_mem_write", {127'h0, mem_write_o}, 128'h0);
        check("rst_mem_address", {100'h0, mem_address_o}, 128'h0);
        check("rst_mem_writedata", mem_writedata_o, 128'h0);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // Clean miss then hits with every load type
        expect_mem(1'b0, 28'h0000004, 128'h0);
        access(LW,  NW, 32'h00000040, 32'h0, 32'h11223344, 5);
        access(NR,  SB, 32'h00000041, 32'h12345680, 32'h0, 0);
        access(LBU, NW, 32'h00000041, 32'h0, 32'h00000080, 0);
        access(LB,  NW, 32'h00000041, 32'h0, 32'hFFFFFF80, 0);
        access(LH,  NW, 32'h00000043, 32'h0, 32'h00001122, 0);
        access(LHU, NW, 32'h00000040, 32'h0, 32'h00008044, 0);
        access(LH,  NW, 32'h00000041, 32'h0, 32'hFFFF8044, 0);
        access(LW,  NW, 32'h00000047, 32'h0, 32'hBBBBAAAA, 0);
        access(LBU, NW, 32'h00000048, 32'h0, 32'h000000CC, 0);
        access(LB,  NW, 32'h0000004A, 32'h0, 32'hFFFFFFDD, 0);
        access(NR,  SH, 32'h00000045, 32'h1234BEEF, 32'h0, 0);
        access(LW,  NW, 32'h00000044, 32'h0, 32'hBBBBBEEF, 0);
        access(NR,  SW, 32'h0000004A, 32'hCAFEF00D, 32'h0, 0);
        access(LW,  NW, 32'h00000048, 32'h0, 32'hCAFEF00D, 0);
        // Load and store together behave as the store
        access(LW,  SB, 32'h0000004F, 32'h0000005A, 32'h0, 0);
        access(LW,  NW, 32'h0000004C, 32'h0, 32'h5AEEFFFF, 0);

        // Dirty eviction at index 4: write back tag 0, then fetch tag 1
        expect_mem(1'b1, 28'h0000004, {32'h5AEEFFFF, 32'hCAFEF00D, 32'hBBBBBEEF, 32'h11228044});
        expect_mem(1'b0, 28'h000000C, 128'h0);
        access(LW,  NW, 32'h000000C0, 32'h0, 32'hA5A50001, -1);
        // Evicted block comes back from memory with the stored bytes
        expect_mem(1'b0, 28'h0000004, 128'h0);
        access(LW,  NW, 32'h00000044, 32'h0, 32'hBBBBBEEF, 5);

        // Reset in the middle of a fetch
        expect_mem(1'b0, 28'h0000010, 128'h0);
        read_i    = LW;
        address_i = 32'h00000100;
        for (int i = 0; i < 20 && !mem_read_o; i++) begin
            @(posedge clk_i);
            #1;
        end
        check("fetch_started", {127'h0, mem_read_o}, 128'h1);
        @(negedge clk_i);
        #2;
        rst_ni = 1'b0;
        #1;
        check("abort_mem_read", {127'h0, mem_read_o}, 128'h0);
        check("abort_mem_address", {100'h0, mem_address_o}, 128'h0);
        check("abort_busywait", {127'h0, busywait_o}, 128'h1);
        read_i = NR;
        @(posedge clk_i);
        #3;
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        check("post_reset_busywait", {127'h0, busywait_o}, 128'h0);
        expect_mem(1'b0, 28'h0000010, 128'h0);
        access(LW,  NW, 32'h00000100, 32'h0, 32'h9ABCDEF0, 5);
        access(LHU, NW, 32'h00000106, 32'h0, 32'h00002222, 0);

        repeat (3) @(posedge clk_i);
        #1;
        check("rsp_queue_drained", rsp_q.size(), 128'h0);
        check("mem_queue_drained", mev_q.size(), 128'h0);
`ifdef DCACHE_STATS_EN
        check("hit_count", {96'h0, hit_count_o}, exp_hits);
        check("miss_count", {96'h0, miss_count_o}, exp_miss);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
